// File: rtl/fer_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// fer_sweep_ctrl_if
// Result-record channel of the FER sweep controller: one record per SNR
// point, moved over a valid/ready handshake.
//
// Signals:
//   res_valid  (master -> slave) record valid
//   res_ready  (slave -> master) consumer ready
//   res_snr    (master -> slave) SNR index of the record
//   res_frames (master -> slave) frames counted at the point  [FRM_W]
//   res_errs   (master -> slave) frame errors at the point     [ERR_W]
//   res_bits   (master -> slave) accumulated bit errors [32], present only
//              when FER_BIT_ERR_EN is defined
// -----------------------------------------------------------------------------
interface fer_sweep_ctrl_if #(
    parameter int FRM_W = 16,
    parameter int ERR_W = 12
);
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_snr;
    logic [FRM_W-1:0] res_frames;
    logic [ERR_W-1:0] res_errs;
`ifdef FER_BIT_ERR_EN
    logic [31:0]      res_bits;

    modport master (
        output res_valid,
        input  res_ready,
        output res_snr,
        output res_frames,
        output res_errs,
        output res_bits
    );

    modport slave (
        input  res_valid,
        output res_ready,
        input  res_snr,
        input  res_frames,
        input  res_errs,
        input  res_bits
    );
`else
    modport master (
        output res_valid,
        input  res_ready,
        output res_snr,
        output res_frames,
        output res_errs
    );

    modport slave (
        input  res_valid,
        output res_ready,
        input  res_snr,
        input  res_frames,
        input  res_errs
    );
`endif
endinterface

// File: rtl/fer_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// fer_sweep_ctrl
// Frame-error-rate sweep controller. Steps the LDPC test harness through SNR
// indices SNR_FIRST..SNR_LAST. At each point the harness is flushed (gen_rst
// held FLUSH_CYC cycles), then decoded frames and frame errors are counted
// until MAX_FRAMES frames or MAX_ERRS errors, and a result record is offered
// on the result channel before moving to the next point.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        start a sweep (accepted in IDLE or DONE only)
//   frame_done   one-cycle pulse per decoded frame
//   frame_err    frame failed, qualified by frame_done
//   bit_errs     [11:0] bit errors of the frame (FER_BIT_ERR_EN only)
//   snr_idx      [3:0] current SNR index to the quantizers
//   frac_w       [4:0] signed quantizer fraction shift (constant FRAC)
//   gen_rst      harness reset: high in IDLE, FLUSH and DONE
//   busy         high in FLUSH, RUN and REPORT
//   done         high in DONE
//   res          result-record channel (fer_sweep_ctrl_if.master)
//
// Optional feature: define FER_BIT_ERR_EN to add the bit_errs input and a
// saturating 32-bit bit-error accumulator reported as res.res_bits.
// -----------------------------------------------------------------------------
module fer_sweep_ctrl #(
    parameter int SNR_FIRST  = 0,
    parameter int SNR_LAST   = 15,
    parameter int FRM_W      = 16,
    parameter int ERR_W      = 12,
    parameter int MAX_FRAMES = 10000,
    parameter int MAX_ERRS   = 100,
    parameter int FRAC       = -1,
    parameter int FLUSH_CYC  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              frame_done,
    input  logic              frame_err,
`ifdef FER_BIT_ERR_EN
    input  logic [11:0]       bit_errs,
`endif
    output logic [3:0]        snr_idx,
    output logic signed [4:0] frac_w,
    output logic              gen_rst,
    output logic              busy,
    output logic              done,
    fer_sweep_ctrl_if.master  res
);

    localparam logic [3:0]        SNR_FIRST_C  = 4'(SNR_FIRST);
    localparam logic [3:0]        SNR_LAST_C   = 4'(SNR_LAST);
    localparam logic [FRM_W-1:0]  MAX_FRAMES_C = FRM_W'(MAX_FRAMES);
    localparam logic [ERR_W-1:0]  MAX_ERRS_C   = ERR_W'(MAX_ERRS);
    localparam logic signed [4:0] FRAC_C       = 5'(FRAC);
    localparam int                FL_W         = $clog2(FLUSH_CYC + 1);
    // The counter starts one below FLUSH_CYC because the cycle that sees zero
    // is itself still a flush cycle.
    localparam logic [FL_W-1:0]   FLUSH_LOAD_C = FL_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_RUN    = 3'd2,
        S_REPORT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

`ifdef FER_BIT_ERR_EN
    // Saturating add of one frame's bit errors into the 32-bit accumulator.
    function automatic logic [31:0] sat_add32(input logic [31:0] acc,
                                              input logic [11:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {21'b0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction
`endif

    state_t            state_q,      state_d;
    logic [3:0]        snr_q,        snr_d;
    logic [FRM_W-1:0]  frames_q,     frames_d;
    logic [ERR_W-1:0]  errs_q,       errs_d;
    logic [FL_W-1:0]   flush_q,      flush_d;
    logic signed [4:0] frac_q,       frac_d;
    logic              gen_rst_q,    gen_rst_d;
    logic              busy_q,       busy_d;
    logic              done_q,       done_d;
    logic              res_valid_q,  res_valid_d;
    logic [3:0]        res_snr_q,    res_snr_d;
    logic [FRM_W-1:0]  res_frames_q, res_frames_d;
    logic [ERR_W-1:0]  res_errs_q,   res_errs_d;
`ifdef FER_BIT_ERR_EN
    logic [31:0]       bits_q,       bits_d;
    logic [31:0]       res_bits_q,   res_bits_d;
    logic [31:0]       bits_inc_s;
`endif

    logic [FRM_W-1:0]  frames_inc_s;
    logic [ERR_W-1:0]  errs_inc_s;
    logic              limit_hit_s;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_d      = state_q;
        snr_d        = snr_q;
        frames_d     = frames_q;
        errs_d       = errs_q;
        flush_d      = flush_q;
        frac_d       = FRAC_C;
        gen_rst_d    = gen_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        res_valid_d  = res_valid_q;
        res_snr_d    = res_snr_q;
        res_frames_d = res_frames_q;
        res_errs_d   = res_errs_q;
`ifdef FER_BIT_ERR_EN
        bits_d       = bits_q;
        res_bits_d   = res_bits_q;
        bits_inc_s   = sat_add32(bits_q, bit_errs);
`endif

        // Post-increment counts for the frame being accepted this cycle; the
        // limit test uses these so the limit-hitting frame is counted exactly
        // once even when both limits trip together.
        frames_inc_s = frames_q + {{(FRM_W-1){1'b0}}, 1'b1};
        errs_inc_s   = errs_q + {{(ERR_W-1){1'b0}}, frame_err};
        limit_hit_s  = (frames_inc_s == MAX_FRAMES_C) || (errs_inc_s == MAX_ERRS_C);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_FLUSH;
                    snr_d     = SNR_FIRST_C;
                    frames_d  = '0;
                    errs_d    = '0;
                    flush_d   = FLUSH_LOAD_C;
                    gen_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
`ifdef FER_BIT_ERR_EN
                    bits_d    = 32'd0;
`endif
                end else begin
                    state_d = state_q;
                end
            end

            S_FLUSH: begin
                // frame_done is deliberately ignored: frames still in flight
                // were produced at the previous SNR point.
                if (flush_q == {FL_W{1'b0}}) begin
                    state_d   = S_RUN;
                    gen_rst_d = 1'b0;
                end else begin
                    flush_d = flush_q - {{(FL_W-1){1'b0}}, 1'b1};
                end
            end

            S_RUN: begin
                if (frame_done) begin
                    frames_d = frames_inc_s;
                    errs_d   = errs_inc_s;
`ifdef FER_BIT_ERR_EN
                    bits_d   = bits_inc_s;
`endif
                    if (limit_hit_s) begin
                        state_d      = S_REPORT;
                        res_valid_d  = 1'b1;
                        res_snr_d    = snr_q;
                        res_frames_d = frames_inc_s;
                        res_errs_d   = errs_inc_s;
`ifdef FER_BIT_ERR_EN
                        res_bits_d   = bits_inc_s;
`endif
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end

            S_REPORT: begin
                if (res_valid_q && res.res_ready) begin
                    res_valid_d = 1'b0;
                    if (snr_q == SNR_LAST_C) begin
                        state_d   = S_DONE;
                        gen_rst_d = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        state_d   = S_FLUSH;
                        snr_d     = snr_q + 4'd1;
                        frames_d  = '0;
                        errs_d    = '0;
                        flush_d   = FLUSH_LOAD_C;
                        gen_rst_d = 1'b1;
`ifdef FER_BIT_ERR_EN
                        bits_d    = 32'd0;
`endif
                    end
                end else begin
                    state_d = S_REPORT;
                end
            end

            default: begin
                state_d     = S_IDLE;
                gen_rst_d   = 1'b1;
                busy_d      = 1'b0;
                done_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset parks the harness in gen_rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            snr_q        <= SNR_FIRST_C;
            frames_q     <= '0;
            errs_q       <= '0;
            flush_q      <= '0;
            frac_q       <= FRAC_C;
            gen_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_snr_q    <= 4'd0;
            res_frames_q <= '0;
            res_errs_q   <= '0;
`ifdef FER_BIT_ERR_EN
            bits_q       <= 32'd0;
            res_bits_q   <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            snr_q        <= snr_d;
            frames_q     <= frames_d;
            errs_q       <= errs_d;
            flush_q      <= flush_d;
            frac_q       <= frac_d;
            gen_rst_q    <= gen_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_valid_q  <= res_valid_d;
            res_snr_q    <= res_snr_d;
            res_frames_q <= res_frames_d;
            res_errs_q   <= res_errs_d;
`ifdef FER_BIT_ERR_EN
            bits_q       <= bits_d;
            res_bits_q   <= res_bits_d;
`endif
        end
    end

    assign snr_idx        = snr_q;
    assign frac_w         = frac_q;
    assign gen_rst        = gen_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign res.res_valid  = res_valid_q;
    assign res.res_snr    = res_snr_q;
    assign res.res_frames = res_frames_q;
    assign res.res_errs   = res_errs_q;
`ifdef FER_BIT_ERR_EN
    assign res.res_bits   = res_bits_q;
`endif

endmodule

// File: tb/tb_fer_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fer_sweep_ctrl
// Three controller instances with different limits are exercised from a table
// of per-point vectors, plus hand-written sequences for reset-in-flight and
// the single-record corner.
//   inst 0: SNR 0..15, MAX_FRAMES 10, MAX_ERRS 100, FLUSH 64, FRAC -1
//   inst 1: SNR 2..3,  MAX_FRAMES 20, MAX_ERRS 3,   FLUSH 4,  FRAC 3
//   inst 2: SNR 5..5,  MAX_FRAMES 3,  MAX_ERRS 3,   FLUSH 4,  FRAC -1
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fer_sweep_ctrl;

    typedef struct {
        int         d;       // instance
        logic [3:0] snr;     // expected SNR of the point
        int         frames;  // expected frame count in the record
        int         errs;    // expected error count in the record
        int         mode;    // 0 no errors, 1 every frame, 2 frames 0,2,4..
        int         stall;   // cycles res_ready held low with frame_done pulsing
        int         flush;   // expected gen_rst flush length
        bit         start;   // issue start before this point
        bit         last;    // last point of the sweep
    } vec_t;

    logic        clk;
    logic        rst_s   [3];
    logic        start_s [3];
    logic        fd_s    [3];
    logic        fe_s    [3];
    logic        rdy_s   [3];
    logic [11:0] bits_s  [3];

    logic [3:0]  snr_o   [3];
    logic [4:0]  frac_o  [3];
    logic        grst_o  [3];
    logic        busy_o  [3];
    logic        done_o  [3];
    logic        rv_o    [3];
    logic [3:0]  rsnr_o  [3];
    logic [15:0] rfr_o   [3];
    logic [11:0] rerr_o  [3];
    logic [31:0] rbits_o [3];

    logic [3:0]  first_snr [3];
    logic [4:0]  exp_frac  [3];

    int n_cmp;
    int n_fail;
    vec_t vecs [19];

    fer_sweep_ctrl_if #(.FRM_W(16), .ERR_W(12)) if_a ();
    fer_sweep_ctrl_if #(.FRM_W(16), .ERR_W(12)) if_b ();
    fer_sweep_ctrl_if #(.FRM_W(16), .ERR_W(12)) if_c ();

    assign if_a.res_ready = rdy_s[0];
    assign if_b.res_ready = rdy_s[1];
    assign if_c.res_ready = rdy_s[2];
    assign rv_o[0] = if_a.res_valid;  assign rsnr_o[0] = if_a.res_snr;
    assign rv_o[1] = if_b.res_valid;  assign rsnr_o[1] = if_b.res_snr;
    assign rv_o[2] = if_c.res_valid;  assign rsnr_o[2] = if_c.res_snr;
    assign rfr_o[0] = if_a.res_frames; assign rerr_o[0] = if_a.res_errs;
    assign rfr_o[1] = if_b.res_frames; assign rerr_o[1] = if_b.res_errs;
    assign rfr_o[2] = if_c.res_frames; assign rerr_o[2] = if_c.res_errs;
`ifdef FER_BIT_ERR_EN
    assign rbits_o[0] = if_a.res_bits;
    assign rbits_o[1] = if_b.res_bits;
    assign rbits_o[2] = if_c.res_bits;
`else
    assign rbits_o[0] = 32'd0;
    assign rbits_o[1] = 32'd0;
    assign rbits_o[2] = 32'd0;
`endif

    fer_sweep_ctrl #(.SNR_FIRST(0), .SNR_LAST(15), .FRM_W(16), .ERR_W(12),
                     .MAX_FRAMES(10), .MAX_ERRS(100), .FRAC(-1), .FLUSH_CYC(64)) dut_a (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .frame_done(fd_s[0]), .frame_err(fe_s[0]),
`ifdef FER_BIT_ERR_EN
        .bit_errs(bits_s[0]),
`endif
        .snr_idx(snr_o[0]), .frac_w(frac_o[0]), .gen_rst(grst_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .res(if_a));

    fer_sweep_ctrl #(.SNR_FIRST(2), .SNR_LAST(3), .FRM_W(16), .ERR_W(12),
                     .MAX_FRAMES(20), .MAX_ERRS(3), .FRAC(3), .FLUSH_CYC(4)) dut_b (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .frame_done(fd_s[1]), .frame_err(fe_s[1]),
`ifdef FER_BIT_ERR_EN
        .bit_errs(bits_s[1]),
`endif
        .snr_idx(snr_o[1]), .frac_w(frac_o[1]), .gen_rst(grst_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .res(if_b));

    fer_sweep_ctrl #(.SNR_FIRST(5), .SNR_LAST(5), .FRM_W(16), .ERR_W(12),
                     .MAX_FRAMES(3), .MAX_ERRS(3), .FRAC(-1), .FLUSH_CYC(4)) dut_c (
        .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .frame_done(fd_s[2]), .frame_err(fe_s[2]),
`ifdef FER_BIT_ERR_EN
        .bit_errs(bits_s[2]),
`endif
        .snr_idx(snr_o[2]), .frac_w(frac_o[2]), .gen_rst(grst_o[2]), .busy(busy_o[2]),
        .done(done_o[2]), .res(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Flush phase with frame_done pulsing throughout; returns observed length.
    task automatic do_flush(input int d, output int cnt);
        cnt = 0;
        while (grst_o[d] === 1'b1 && cnt < 300) begin
            fd_s[d] = 1'b1; fe_s[d] = 1'b1; bits_s[d] = 12'd7;
            cnt++;
            step();
        end
        fd_s[d] = 1'b0; fe_s[d] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  cnt;
        int  i;
        bit  ok;
        if (v.start) begin
            start_s[v.d] = 1'b1;
            step();
            start_s[v.d] = 1'b0;
            chk("start_busy", 32'(busy_o[v.d]), 32'd1);
            chk("start_snr", 32'(snr_o[v.d]), 32'(v.snr));
            chk("start_done_low", 32'(done_o[v.d]), 32'd0);
        end
        do_flush(v.d, cnt);
        chk("flush_len", 32'(cnt), 32'(v.flush));
        chk("run_snr", 32'(snr_o[v.d]), 32'(v.snr));
        i = 0;
        while (rv_o[v.d] !== 1'b1 && i < 200) begin
            fd_s[v.d]   = 1'b1;
            fe_s[v.d]   = (v.mode == 1) || (v.mode == 2 && (i % 2) == 0);
            bits_s[v.d] = 12'd7;
            step();
            i++;
        end
        fd_s[v.d] = 1'b0; fe_s[v.d] = 1'b0;
        chk("frames_to_valid", 32'(i), 32'(v.frames));
        chk("rec_valid", 32'(rv_o[v.d]), 32'd1);
        chk("rec_snr", 32'(rsnr_o[v.d]), 32'(v.snr));
        chk("rec_frames", 32'(rfr_o[v.d]), 32'(v.frames));
        chk("rec_errs", 32'(rerr_o[v.d]), 32'(v.errs));
`ifdef FER_BIT_ERR_EN
        chk("rec_bits", rbits_o[v.d], 32'(7 * v.frames));
`endif
        ok = 1'b1;
        for (int s = 0; s < v.stall; s++) begin
            fd_s[v.d] = 1'b1; fe_s[v.d] = 1'b1;
            step();
            if (rv_o[v.d] !== 1'b1 || rsnr_o[v.d] !== v.snr ||
                rfr_o[v.d] !== 16'(v.frames) || rerr_o[v.d] !== 12'(v.errs) ||
                grst_o[v.d] !== 1'b0) ok = 1'b0;
        end
        fd_s[v.d] = 1'b0; fe_s[v.d] = 1'b0;
        if (v.stall > 0) chk("stall_hold", 32'(ok), 32'd1);
        rdy_s[v.d] = 1'b1;
        step();
        rdy_s[v.d] = 1'b0;
        chk("hs_valid_low", 32'(rv_o[v.d]), 32'd0);
        chk("hs_gen_rst", 32'(grst_o[v.d]), 32'd1);
        if (v.last) begin
            chk("hs_done", 32'(done_o[v.d]), 32'd1);
            chk("hs_busy_low", 32'(busy_o[v.d]), 32'd0);
        end else begin
            chk("hs_next_snr", 32'(snr_o[v.d]), 32'(v.snr) + 32'd1);
            chk("hs_busy", 32'(busy_o[v.d]), 32'd1);
        end
    endtask

    task automatic chk_reset_vals(input int d);
        chk("rst_snr", 32'(snr_o[d]), 32'(first_snr[d]));
        chk("rst_frac", 32'(frac_o[d]), 32'(exp_frac[d]));
        chk("rst_gen_rst", 32'(grst_o[d]), 32'd1);
        chk("rst_busy", 32'(busy_o[d]), 32'd0);
        chk("rst_done", 32'(done_o[d]), 32'd0);
        chk("rst_valid", 32'(rv_o[d]), 32'd0);
        chk("rst_res_snr", 32'(rsnr_o[d]), 32'd0);
        chk("rst_res_frames", 32'(rfr_o[d]), 32'd0);
        chk("rst_res_errs", 32'(rerr_o[d]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        vec_t v;
        n_cmp  = 0;
        n_fail = 0;
        first_snr[0] = 4'd0; first_snr[1] = 4'd2;  first_snr[2] = 4'd5;
        exp_frac[0]  = 5'h1F; exp_frac[1] = 5'h03; exp_frac[2] = 5'h1F;
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1; start_s[k] = 1'b0; fd_s[k] = 1'b0;
            fe_s[k] = 1'b0; rdy_s[k] = 1'b0; bits_s[k] = 12'd0;
        end

        // Inst 0: full 16-point sweep, 10 clean frames per point.
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{d: 0, snr: 4'(k), frames: 10, errs: 0, mode: 0, stall: 0,
                        flush: 64, start: (k == 0), last: (k == 15)};
        end
        // Inst 1: error limit with every frame failing, record held 20 cycles;
        // then error limit reached on alternating errors.
        vecs[16] = '{d: 1, snr: 4'd2, frames: 3, errs: 3, mode: 1, stall: 20,
                     flush: 4, start: 1'b1, last: 1'b0};
        vecs[17] = '{d: 1, snr: 4'd3, frames: 5, errs: 3, mode: 2, stall: 0,
                     flush: 4, start: 1'b0, last: 1'b1};
        // Inst 2: both limits on the same frame.
        vecs[18] = '{d: 2, snr: 4'd5, frames: 3, errs: 3, mode: 1, stall: 3,
                     flush: 4, start: 1'b1, last: 1'b1};

        step();
        for (int k = 0; k < 3; k++) chk_reset_vals(k);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("idle_gen_rst", 32'(grst_o[k]), 32'd1);
            chk("idle_busy", 32'(busy_o[k]), 32'd0);
        end

        for (int k = 0; k < 19; k++) run_vec(vecs[k]);

        // Only one record from the double-limit frame.
        step(); step(); step();
        chk("single_record", 32'(rv_o[2]), 32'd0);
        chk("single_done", 32'(done_o[2]), 32'd1);

        // Reset in the middle of RUN at frames=5 on inst 1.
        start_s[1] = 1'b1;
        step();
        start_s[1] = 1'b0;
        do_flush(1, cnt);
        chk("mid_flush_len", 32'(cnt), 32'd4);
        for (int f = 0; f < 5; f++) begin
            fd_s[1] = 1'b1; fe_s[1] = 1'b0; step();
        end
        fd_s[1] = 1'b0;
        chk("mid_run_no_valid", 32'(rv_o[1]), 32'd0);
        chk("mid_run_gen_rst", 32'(grst_o[1]), 32'd0);
        #2;
        rst_s[1] = 1'b1;
        #1;
        chk_reset_vals(1);
        step();
        rst_s[1] = 1'b0;
        step();
        v = '{d: 1, snr: 4'd2, frames: 20, errs: 0, mode: 0, stall: 0,
              flush: 4, start: 1'b1, last: 1'b0};
        run_vec(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fer_sweep_ctrl.md
# fer_sweep_ctrl

Frame-error-rate sweep controller sitting directly downstream of the LDPC decoder test harness. It consumes per-frame decode completion and error flags and drives the harness SNR point (`snr_idx`, `frac_w`). It accumulates frame and error counts per SNR point, stopping each point on a frame or error limit. It then reports one result record per point over a valid/ready handshake and steps through the configured SNR range.

## Interface
Parameters:
- `SNR_FIRST`, 0: first SNR index of the sweep (4-bit value).
- `SNR_LAST`, 15: last SNR index, inclusive; must be ≥ `SNR_FIRST`.
- `FRM_W`, 16: frame counter width.
- `ERR_W`, 12: error counter width.
- `MAX_FRAMES`, 10000: frames per point; must be < 2^`FRM_W`.
- `MAX_ERRS`, 100: errors per point; must be < 2^`ERR_W`.
- `FRAC`, -1: constant driven on `frac_w`.
- `FLUSH_CYC`, 64: cycles `gen_rst` is held after each SNR change.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: **asynchronous, active-high** reset.
- `start`, in, 1: start sweep; sampled only in IDLE or DONE.
- `frame_done`, in, 1: one-cycle pulse per decoded frame (decoder `term` edge).
- `frame_err`, in, 1: frame failed; qualified by `frame_done`.
- `snr_idx`, out, 4: current SNR index to the quantizers.
- `frac_w`, out, 5 signed: quantizer fraction shift; equals `FRAC`.
- `gen_rst`, out, 1: resets noise generators, buffers and decoder.
- `res_valid`, out, 1: result record valid.
- `res_ready`, in, 1: result consumer ready.
- `res_snr`, out, 4: SNR index of the record.
- `res_frames`, out, `FRM_W`: frames counted at the point.
- `res_errs`, out, `ERR_W`: frame errors counted at the point.
- `busy`, out, 1: high in FLUSH, RUN and REPORT.
- `done`, out, 1: high in DONE.

## Operation
- States: IDLE, FLUSH, RUN, REPORT, DONE.
- IDLE: on `start`, load `snr_idx`=`SNR_FIRST`, clear counters, load flush counter, go to FLUSH.
- FLUSH: `gen_rst`=1. Count down `FLUSH_CYC` cycles, then go to RUN. `frame_done` is ignored, so frames generated at the old SNR are discarded.
- RUN: on each `frame_done`, increment frames. If `frame_err` is also set, increment errors.
  - Go to REPORT when the post-increment frames == `MAX_FRAMES` or errors == `MAX_ERRS`.
  - If both limits are hit on the same frame, that frame is counted once and a single record is produced.
- REPORT: `res_valid`=1 and the record stays stable until `res_ready`. On the handshake:
  - if `snr_idx`==`SNR_LAST`, go to DONE;
  - otherwise increment `snr_idx`, clear counters and go to FLUSH.
- `frame_done` arriving in REPORT, IDLE or DONE is dropped and not counted.
- DONE: `done`=1. `start` restarts from `SNR_FIRST` as in IDLE.
- `start` in FLUSH, RUN or REPORT is ignored.
- Counters never wrap: the limits are below the width maxima, so RUN always exits first.
- Reset mid-sweep: every register clears immediately and the state returns to IDLE. No partial record is emitted.

## Timing
- Reset values:
  - state IDLE; `snr_idx`=`SNR_FIRST`; `frac_w`=`FRAC`.
  - `gen_rst`=1, which holds the harness in reset while idle.
  - `res_valid`=0, `res_snr`=0, `res_frames`=0, `res_errs`=0, `busy`=0, `done`=0.
- `gen_rst` is 1 in IDLE, FLUSH and DONE, and 0 in RUN and REPORT.
- `start` at edge k: FLUSH from k+1. `gen_rst` stays high exactly `FLUSH_CYC` cycles (k+1 … k+`FLUSH_CYC`), and RUN begins at k+`FLUSH_CYC`+1.
- Counter updates are registered and visible one cycle after `frame_done`.
- The limit-hitting frame at edge k gives `res_valid`=1 from k+1, carrying the final counts.
- A handshake at edge k gives `res_valid`=0 from k+1, together with the new `snr_idx` and `gen_rst`=1, or with `done`=1.
- Throughput is one frame per cycle maximum. Back-to-back `frame_done` pulses are all counted.

## Configuration
- Macro `FER_BIT_ERR_EN`.
- Defined: adds input `bit_errs` [11:0] (bit errors of the frame, qualified by `frame_done`) and output `res_bits` [31:0].
  - `res_bits` accumulates `bit_errs` over the frames counted in RUN, saturating at 2^32-1.
  - It clears with the other counters and is reported with the record.
- Undefined: neither port exists and there is no accumulator. Frame counting behaviour is identical.

## Test plan
- Reset, then `start` with `FLUSH_CYC`=64: `gen_rst` high for exactly 64 cycles, then low; `snr_idx`=`SNR_FIRST`; `busy`=1.
- `MAX_FRAMES`=10, no errors, `res_ready`=1 → one record per point with `res_frames`=10 and `res_errs`=0. `snr_idx` steps 0…15, then `done`=1.
- `MAX_ERRS`=3 with every frame in error → record has `res_frames`=3, `res_errs`=3; both limits on the same frame with `MAX_FRAMES`=3 → exactly one record.
- `frame_done` pulsed during FLUSH and while `res_valid`=1 with `res_ready`=0 for 20 cycles → no count change. The record is held stable and advances only after `res_ready` rises.
- `rst` asserted mid-RUN at frames=5 → outputs take reset values without waiting for a clock edge. A new `start` begins from `SNR_FIRST` with zero counts.
- With `FER_BIT_ERR_EN` defined: 4 frames with `bit_errs`=7 → `res_bits`=28. A build without the macro elaborates with the ports absent.
